// File: rtl/phased_array_pkg.sv
// Shared definitions for the phased-array controller: opcodes, response codes,
// framing constants and byte-packing helpers for the 7-bit payload protocol.
package phased_array_pkg;

   localparam int FRAME_LEN = 4;

   localparam logic [2:0] OP_SET_PHASE  = 3'd0;
   localparam logic [2:0] OP_SET_DUTY   = 3'd1;
   localparam logic [2:0] OP_COMMIT     = 3'd2;
   localparam logic [2:0] OP_ENABLE     = 3'd3;
   localparam logic [2:0] OP_QUERY      = 3'd4;
   localparam logic [2:0] OP_READ_PHASE = 3'd5;

   localparam logic [7:0] RSP_ACK    = 8'hA5;
   localparam logic [7:0] RSP_BADCH  = 8'hFE;
   localparam logic [7:0] RSP_BADVAL = 8'hFD;
   localparam logic [7:0] RSP_BADOP  = 8'hFF;

   typedef enum logic [1:0] {
      ST_COLLECT = 2'd0,
      ST_EXEC    = 2'd1,
      ST_RESP    = 2'd2
   } ctrl_state_t;

   function automatic logic [7:0] hi_byte(input logic [13:0] v);
      return {1'b0, v[13:7]};
   endfunction

   function automatic logic [7:0] lo_byte(input logic [13:0] v);
      return {1'b0, v[6:0]};
   endfunction

endpackage

// File: rtl/phased_array_ctrl_phase_channel.sv
// One transducer output: registered compare of the phase-shifted period
// position against the channel's duty, gated by the global enable.
module phase_channel
   import phased_array_pkg::*;
#(
   parameter int PHASE_W = 12,
   parameter int PERIOD  = 1250
)(
   input  logic               clk,
   input  logic               rst,
   input  logic [PHASE_W-1:0] cnt,
   input  logic [PHASE_W-1:0] phase,
   input  logic [PHASE_W-1:0] duty,
   input  logic               enable,
   output logic               tx
);

   localparam int PW1 = PHASE_W + 1;
   localparam logic signed [PHASE_W:0] PERIOD_S = PW1'(PERIOD);

   logic tx_p1;

   // (cnt - phase) mod PERIOD; phase is always < PERIOD so one fold suffices
   function automatic logic [PHASE_W-1:0] wrap_offset(input logic [PHASE_W-1:0] c,
                                                      input logic [PHASE_W-1:0] p);
      logic signed [PHASE_W:0] d;
      d = $signed({1'b0, c}) - $signed({1'b0, p});
      if (d < 0)
         d = d + PERIOD_S;
      return d[PHASE_W-1:0];
   endfunction

   // p0 -> p1: compare registered onto the output
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         tx_p1 <= 1'b0;
      else
         tx_p1 <= enable && (wrap_offset(cnt, phase) < duty);
   end

   assign tx = tx_p1;

endmodule

// File: rtl/phased_array_ctrl.sv
// Byte-stream controlled transducer array driver with double-buffered phase
// and duty registers that swap only on a drive-period boundary.
module phased_array_ctrl
   import phased_array_pkg::*;
#(
   parameter int CHANNELS = 88,
   parameter int CLK_HZ   = 50000000,
   parameter int FREQ_HZ  = 40000,
   parameter int PHASE_W  = 12
)(
   input  logic                clk,
   input  logic                rst,
   input  logic [7:0]          in_data,
   input  logic                in_valid,
   output logic                in_ready,
   output logic [7:0]          out_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [CHANNELS-1:0] tx,
   output logic                sync_out,
   output logic                enabled,
   output logic                commit_pending
);

   localparam int PERIOD = CLK_HZ / FREQ_HZ;
   localparam int CH_IW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam logic [PHASE_W-1:0] LAST_P   = PHASE_W'(PERIOD - 1);
   localparam logic [PHASE_W-1:0] HALF_P   = PHASE_W'(PERIOD / 2);
   localparam logic [13:0]        PERIOD_V = 14'(PERIOD);
   localparam logic [13:0]        CH_V     = 14'(CHANNELS);
   localparam logic [11:0]        CH_LIM   = 12'(CHANNELS);
   localparam logic [1:0]         LAST_IDX = 2'(FRAME_LEN - 1);

   ctrl_state_t state, state_nx;

   logic [PHASE_W-1:0] cnt;
   logic               sync_p1;
   logic               enabled_r;
   logic               pending_r;
   logic               ack_pend;
   logic               frame_open;
   logic [1:0]         byte_idx;
   logic [6:0]         hdr, ch_lo, val_hi, val_lo;
   logic [1:0]         resp_len, resp_sent;
   logic [7:0]         resp0, resp1;
   logic [7:0]         out_data_r;
   logic               out_valid_r;

   logic [PHASE_W-1:0] shadow_phase [CHANNELS];
   logic [PHASE_W-1:0] shadow_duty  [CHANNELS];
   logic [PHASE_W-1:0] active_phase [CHANNELS];
   logic [PHASE_W-1:0] active_duty  [CHANNELS];

   logic [2:0]       op;
   logic [10:0]      ch;
   logic [13:0]      val;
   logic [CH_IW-1:0] idx;
   logic             ch_ok;
   logic             at_wrap, apply;
   logic             wr_phase, wr_duty, exec_commit, exec_enable;
   logic [1:0]       dec_len;
   logic [7:0]       dec_b0, dec_b1;
   logic             frame_last, resp_load, ack_load, out_free;

   assign op    = hdr[6:4];
   assign ch    = {hdr[3:0], ch_lo};
   assign val   = {val_hi, val_lo};
   assign idx   = ch[CH_IW-1:0];
   assign ch_ok = ({1'b0, ch} < CH_LIM);

   assign at_wrap  = (cnt == LAST_P);
   assign apply    = at_wrap && (pending_r || exec_commit);
   assign out_free = !out_valid_r || out_ready;
   assign ack_load = (state == ST_COLLECT) && ack_pend && out_free;

   assign in_ready       = (state == ST_COLLECT);
   assign out_data       = out_data_r;
   assign out_valid      = out_valid_r;
   assign sync_out       = sync_p1;
   assign enabled        = enabled_r;
   assign commit_pending = pending_r;

   // Decode of the captured frame; only meaningful in EXEC
   always_comb begin
      wr_phase    = 1'b0;
      wr_duty     = 1'b0;
      exec_commit = 1'b0;
      exec_enable = 1'b0;
      dec_len     = 2'd0;
      dec_b0      = 8'h00;
      dec_b1      = 8'h00;
      if (state == ST_EXEC) begin
         case (op)
            OP_SET_PHASE: begin
               if (!ch_ok) begin
                  dec_len = 2'd1;
                  dec_b0  = RSP_BADCH;
               end else if (val >= PERIOD_V) begin
                  dec_len = 2'd1;
                  dec_b0  = RSP_BADVAL;
               end else begin
                  wr_phase = 1'b1;
               end
            end
            OP_SET_DUTY: begin
               if (!ch_ok) begin
                  dec_len = 2'd1;
                  dec_b0  = RSP_BADCH;
               end else if (val > PERIOD_V) begin
                  dec_len = 2'd1;
                  dec_b0  = RSP_BADVAL;
               end else begin
                  wr_duty = 1'b1;
               end
            end
            OP_COMMIT: exec_commit = 1'b1;
            OP_ENABLE: exec_enable = 1'b1;
            OP_QUERY: begin
               dec_len = 2'd2;
               dec_b0  = hi_byte(CH_V);
               dec_b1  = lo_byte(CH_V);
            end
            OP_READ_PHASE: begin
               if (!ch_ok) begin
                  dec_len = 2'd1;
                  dec_b0  = RSP_BADCH;
               end else begin
                  dec_len = 2'd2;
                  dec_b0  = hi_byte(14'(shadow_phase[idx]));
                  dec_b1  = lo_byte(14'(shadow_phase[idx]));
               end
            end
            default: begin
               dec_len = 2'd1;
               dec_b0  = RSP_BADOP;
            end
         endcase
      end
   end

   always_comb begin
      state_nx   = state;
      frame_last = 1'b0;
      resp_load  = 1'b0;
      case (state)
         ST_COLLECT: begin
            frame_last = in_valid && !in_data[7] && frame_open && (byte_idx == LAST_IDX);
            if (frame_last)
               state_nx = ST_EXEC;
         end
         ST_EXEC: begin
            state_nx = (dec_len != 2'd0) ? ST_RESP : ST_COLLECT;
         end
         ST_RESP: begin
            resp_load = (resp_sent != resp_len) && out_free;
            // leave only once our last byte has actually been taken
            if ((resp_sent == resp_len) && out_valid_r && out_ready)
               state_nx = ST_COLLECT;
         end
         default: state_nx = ST_COLLECT;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state <= ST_COLLECT;
      else
         state <= state_nx;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         frame_open <= 1'b0;
         byte_idx   <= 2'd0;
         hdr        <= '0;
         ch_lo      <= '0;
         val_hi     <= '0;
         val_lo     <= '0;
      end else if (state == ST_COLLECT && in_valid) begin
         if (in_data[7]) begin
            frame_open <= 1'b1;
            byte_idx   <= 2'd1;
            hdr        <= in_data[6:0];
         end else if (frame_open) begin
            case (byte_idx)
               2'd1:    ch_lo  <= in_data[6:0];
               2'd2:    val_hi <= in_data[6:0];
               default: val_lo <= in_data[6:0];
            endcase
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == LAST_IDX)
               frame_open <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt       <= '0;
         sync_p1   <= 1'b0;
         enabled_r <= 1'b0;
         pending_r <= 1'b0;
         ack_pend  <= 1'b0;
      end else begin
         cnt       <= at_wrap ? '0 : cnt + 1'b1;
         sync_p1   <= (cnt < HALF_P);
         if (exec_enable)
            enabled_r <= val[0];
         pending_r <= apply ? 1'b0 : (pending_r || exec_commit);
         ack_pend  <= apply || (ack_pend && !ack_load);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         resp_len    <= 2'd0;
         resp_sent   <= 2'd0;
         resp0       <= 8'h00;
         resp1       <= 8'h00;
         out_data_r  <= 8'h00;
         out_valid_r <= 1'b0;
      end else begin
         if (state == ST_EXEC) begin
            resp_len  <= dec_len;
            resp_sent <= 2'd0;
            resp0     <= dec_b0;
            resp1     <= dec_b1;
         end
         if (resp_load) begin
            out_data_r  <= (resp_sent == 2'd0) ? resp0 : resp1;
            out_valid_r <= 1'b1;
            resp_sent   <= resp_sent + 2'd1;
         end else if (ack_load) begin
            out_data_r  <= RSP_ACK;
            out_valid_r <= 1'b1;
         end else if (out_ready) begin
            out_valid_r <= 1'b0;
         end
      end
   end

   // Shadow writes land immediately; the active copy swaps on the period wrap
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < CHANNELS; k++) begin
            shadow_phase[k] <= '0;
            shadow_duty[k]  <= HALF_P;
            active_phase[k] <= '0;
            active_duty[k]  <= HALF_P;
         end
      end else begin
         if (wr_phase)
            shadow_phase[idx] <= val[PHASE_W-1:0];
         if (wr_duty)
            shadow_duty[idx] <= val[PHASE_W-1:0];
         if (apply) begin
            for (int k = 0; k < CHANNELS; k++) begin
               active_phase[k] <= shadow_phase[k];
               active_duty[k]  <= shadow_duty[k];
            end
         end
      end
   end

   for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
      phase_channel #(
         .PHASE_W (PHASE_W),
         .PERIOD  (PERIOD)
      ) u_ch (
         .clk    (clk),
         .rst    (rst),
         .cnt    (cnt),
         .phase  (active_phase[k]),
         .duty   (active_duty[k]),
         .enable (enabled_r),
         .tx     (tx[k])
      );
   end

endmodule

// File: tb/tb_phased_array_ctrl.sv
// Scoreboard bench for phased_array_ctrl: directed command frames, expected
// response bytes queued at issue time and popped by an output monitor.
module tb_phased_array_ctrl;
   import phased_array_pkg::*;

   localparam int CH  = 88;
   localparam int PER = 1250;

   logic          clk = 1'b0;
   logic          rst;
   logic [7:0]    in_data;
   logic          in_valid;
   logic          in_ready;
   logic [7:0]    out_data;
   logic          out_valid;
   logic          out_ready;
   logic [CH-1:0] tx;
   logic          sync_out;
   logic          enabled;
   logic          commit_pending;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   logic [7:0] exp_q [$];

   phased_array_ctrl dut (
      .clk            (clk),
      .rst            (rst),
      .in_data        (in_data),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .out_data       (out_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .tx             (tx),
      .sync_out       (sync_out),
      .enabled        (enabled),
      .commit_pending (commit_pending)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Response monitor
   always @(negedge clk) begin
      if (rst === 1'b1 && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_byte: got %02h expected nothing", out_data);
         end else begin
            check("out_byte", out_data, exp_q.pop_front());
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      bit ok;
      ok = 1'b0;
      in_data  = b;
      in_valid = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("in_ready_wait", in_ready, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [2:0] op, input logic [10:0] ch, input logic [13:0] v);
      send_byte({1'b1, op, ch[10:7]});
      send_byte({1'b0, ch[6:0]});
      send_byte({1'b0, v[13:7]});
      send_byte({1'b0, v[6:0]});
   endtask

   task automatic wait_drain(input string name);
      for (int i = 0; i < 5000; i++) begin
         if (exp_q.size() == 0) break;
         @(negedge clk);
      end
      check({name, "_drained"}, exp_q.size(), 0);
      repeat (3) @(negedge clk);
   endtask

   task automatic wait_sync_rise();
      logic prev;
      bit   found;
      found = 1'b0;
      @(negedge clk);
      prev = sync_out;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (!prev && sync_out) begin
            found = 1'b1;
            break;
         end
         prev = sync_out;
      end
      check("sync_rise_seen", found, 1);
   endtask

   // One period from a sync rise: sample j reflects cnt == j
   task automatic check_pattern(input string name, input int ph5, input int du5,
                                output int rise5, output int high5);
      int  err5, errk;
      logic e5, ek;
      err5 = 0; errk = 0; rise5 = -1; high5 = 0;
      wait_sync_rise();
      for (int j = 0; j < PER; j++) begin
         if (j > 0) @(negedge clk);
         e5 = ((((j - ph5) % PER) + PER) % PER) < du5;
         ek = (j < PER / 2);
         if (tx[5] !== e5) err5++;
         if (tx[5] === 1'b1) begin
            high5++;
            if (rise5 < 0) rise5 = j;
         end
         for (int k = 0; k < CH; k++)
            if (k != 5 && tx[k] !== ek) errk++;
      end
      check({name, "_ch5"}, err5, 0);
      check({name, "_others"}, errk, 0);
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int hi, serr, bad_tx, bad_ov, r, h, err, rt;
      bit seen;
      rst       = 1'b0;
      in_data   = 8'h00;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_tx",        tx == '0, 1);
      check("rst_sync",      sync_out, 0);
      check("rst_enabled",   enabled, 0);
      check("rst_pending",   commit_pending, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data",  out_data, 8'h00);
      check("rst_in_ready",  in_ready, 1);
      @(posedge clk); #1 rst = 1'b1;

      // Idle: sync period and duty, outputs silent
      wait_sync_rise();
      hi = 0; serr = 0; bad_tx = 0; bad_ov = 0;
      for (int j = 0; j < PER; j++) begin
         if (j > 0) @(negedge clk);
         if (sync_out) hi++;
         if (sync_out !== (j < PER / 2)) serr++;
         if (tx !== '0) bad_tx++;
         if (out_valid) bad_ov++;
      end
      @(negedge clk);
      check("sync_high_cycles", hi, 625);
      check("sync_shape", serr, 0);
      check("sync_wraps_1250", sync_out, 1);
      check("idle_tx_zero", bad_tx, 0);
      check("idle_no_out", bad_ov, 0);

      // Enable + commit: one ack, defaults track sync
      wait_sync_rise();
      send_frame(OP_ENABLE, 11'd0, 14'd1);
      repeat (2) @(negedge clk);
      check("enabled_set", enabled, 1);
      exp_q.push_back(8'hA5);
      send_frame(OP_COMMIT, 11'd0, 14'd0);
      repeat (2) @(negedge clk);
      check("pending_after_commit", commit_pending, 1);
      wait_drain("ack1");
      check("pending_cleared", commit_pending, 0);
      check_pattern("default", 0, 625, r, h);
      check("default_rise", r, 0);
      check("default_high", h, 625);

      // Shadowed ch5 update with merged double commit
      wait_sync_rise();
      send_frame(OP_SET_PHASE, 11'd5, 14'd625);
      send_frame(OP_SET_DUTY,  11'd5, 14'd250);
      exp_q.push_back(8'hA5);
      send_frame(OP_COMMIT, 11'd0, 14'd0);
      send_frame(OP_COMMIT, 11'd0, 14'd0);
      @(negedge clk);
      check("pending_merged", commit_pending, 1);
      err = 0;
      for (int i = 0; i < 2000 && commit_pending; i++) begin
         if (tx[5] !== sync_out) err++;
         @(negedge clk);
      end
      check("ch5_held_until_wrap", err, 0);
      wait_drain("ack2");
      check_pattern("ch5_new", 625, 250, r, h);
      check("ch5_rise_offset", r, 625);
      check("ch5_high_len", h, 250);

      // Error and read-back responses
      exp_q.push_back(RSP_BADCH);
      send_frame(OP_SET_PHASE, 11'd88, 14'd10);
      exp_q.push_back(RSP_BADCH);
      send_frame(OP_SET_PHASE, 11'd2047, 14'd10);
      exp_q.push_back(RSP_BADVAL);
      send_frame(OP_SET_PHASE, 11'd3, 14'd1250);
      send_frame(OP_SET_DUTY, 11'd3, 14'd1250);
      exp_q.push_back(RSP_BADVAL);
      send_frame(OP_SET_DUTY, 11'd3, 14'd1251);
      exp_q.push_back(RSP_BADOP);
      send_frame(3'd7, 11'd0, 14'd0);
      exp_q.push_back(RSP_BADOP);
      send_frame(3'd6, 11'd0, 14'd0);
      exp_q.push_back(8'h00); exp_q.push_back(8'h00);
      send_frame(OP_READ_PHASE, 11'd3, 14'd0);
      exp_q.push_back(8'h04); exp_q.push_back(8'h71);
      send_frame(OP_READ_PHASE, 11'd5, 14'd0);
      send_frame(OP_SET_PHASE, 11'd87, 14'd1249);
      exp_q.push_back(8'h09); exp_q.push_back(8'h61);
      send_frame(OP_READ_PHASE, 11'd87, 14'd0);
      exp_q.push_back(RSP_BADCH);
      send_frame(OP_READ_PHASE, 11'd88, 14'd0);
      wait_drain("errors");

      // Stalled QUERY straddling a commit boundary: ack held behind it
      wait_sync_rise();
      rt = cyc;
      send_frame(OP_COMMIT, 11'd0, 14'd0);
      while (cyc < rt + 1195) @(negedge clk);
      out_ready = 1'b0;
      exp_q.push_back(8'h00); exp_q.push_back(8'h58); exp_q.push_back(8'hA5);
      send_frame(OP_QUERY, 11'd0, 14'd0);
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (out_valid) begin seen = 1'b1; break; end
      end
      check("query_valid_seen", seen, 1);
      err = 0;
      for (int i = 0; i < 20; i++) begin
         if (!(out_valid && out_data == 8'h00 && !in_ready)) err++;
         @(negedge clk);
      end
      check("query_stall_stable", err, 0);
      while (cyc < rt + 1270) @(negedge clk);
      check("commit_in_resp", commit_pending, 0);
      check("ack_behind_resp", out_data, 8'h00);
      @(posedge clk); #1 out_ready = 1'b1;
      wait_drain("query");

      // Framing: stray data byte, truncated frame, then a full one
      send_byte(8'h12);
      send_byte({1'b1, OP_QUERY, 4'h0});
      send_byte(8'h00);
      send_byte(8'h00);
      exp_q.push_back(8'h04); exp_q.push_back(8'h71);
      send_frame(OP_READ_PHASE, 11'd5, 14'd0);
      wait_drain("framing");

      // Reset in the middle of a response
      out_ready = 1'b0;
      send_frame(OP_QUERY, 11'd0, 14'd0);
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (out_valid) begin seen = 1'b1; break; end
      end
      check("rst_test_valid_seen", seen, 1);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("midrst_out_valid", out_valid, 0);
      check("midrst_out_data",  out_data, 8'h00);
      check("midrst_in_ready",  in_ready, 1);
      check("midrst_enabled",   enabled, 0);
      check("midrst_pending",   commit_pending, 0);
      check("midrst_tx",        tx == '0, 1);
      check("midrst_sync",      sync_out, 0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1 rst = 1'b1;
      exp_q.push_back(8'h00); exp_q.push_back(8'h00);
      send_frame(OP_READ_PHASE, 11'd5, 14'd0);
      wait_drain("post_rst_read");
      send_frame(OP_ENABLE, 11'd0, 14'd1);
      check_pattern("post_rst", 0, 625, r, h);
      check("post_rst_high", h, 625);
      repeat (5) @(negedge clk);
      check("final_queue_empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
